led_blinker_top: RTL and testbench



---
 rtl/led_blinker_pkg.sv | 36 +++
 rtl/led_blinker_top_tick.sv | 33 +++
 rtl/led_blinker_top.sv | 68 ++++++
 tb/tb_led_blinker_top.sv | 123 ++++++++++++
 4 files changed

// File: rtl/led_blinker_pkg.sv
// Shared types and pattern rules for the LED blinker fabric.
package led_blinker_pkg;

   localparam int unsigned LED_W  = 4;
   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_COUNT = 2'd3
   } mode_t;

   // Pattern shown on the cycle after a mode is loaded.
   function automatic logic [LED_W-1:0] pat_init(input mode_t m);
      logic [LED_W-1:0] v;
      v = '0;
      if (m == MODE_WALK) v = LED_W'(1);
      return v;
   endfunction

   // Pattern after one step from the current LED state.
   function automatic logic [LED_W-1:0] pat_next(input mode_t m, input logic [LED_W-1:0] led);
      logic [LED_W-1:0] v;
      v = '0;
      case (m)
         MODE_OFF:   v = '0;
         MODE_BLINK: v = ~led;
         MODE_WALK:  v = {led[LED_W-2:0], led[LED_W-1]};
         MODE_COUNT: v = led + LED_W'(1);
         default:    v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/led_blinker_top_tick.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr.
module led_tick_gen
   import led_blinker_pkg::*;
#(
   parameter int unsigned TICK_DIV = 10_000_000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_LAST);
   assign tick   = w_last;

   // rstn is active-high: 1 clears the counter.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_cnt <= '0;
      end else if (clr || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_blinker_top.sv
// Top of the LED blinker fabric: mode register, LED pattern register and step logic.
module led_blinker_top
   import led_blinker_pkg::*;
#(
   parameter int unsigned TICK_DIV = 10_000_000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [MODE_W-1:0] inSwitch,
   input  logic              valid,
   output logic              outBit1,
   output logic              outBit2,
   output logic              outBit3,
   output logic              outBit4
);

   mode_t            r_mode;
   logic [LED_W-1:0] r_led;

   mode_t            w_mode_d;
   mode_t            w_sw_mode;
   logic [LED_W-1:0] w_led_d;
   logic             w_load;
   logic             w_tick;

   // Reload only on an actual mode change so a held valid never restarts the pattern.
   assign w_sw_mode = mode_t'(inSwitch);
   assign w_load    = valid && (w_sw_mode != r_mode);

   led_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .clr  (w_load),
      .tick (w_tick)
   );

   // Load wins over a coincident tick.
   always_comb begin
      w_mode_d = r_mode;
      w_led_d  = r_led;
      if (w_load) begin
         w_mode_d = w_sw_mode;
         w_led_d  = pat_init(w_sw_mode);
      end else if (w_tick) begin
         w_led_d  = pat_next(r_mode, r_led);
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_mode <= MODE_OFF;
         r_led  <= '0;
      end else begin
         r_mode <= w_mode_d;
         r_led  <= w_led_d;
      end
   end

   assign outBit1 = r_led[0];
   assign outBit2 = r_led[1];
   assign outBit3 = r_led[2];
   assign outBit4 = r_led[3];

endmodule

// File: tb/tb_led_blinker_top.sv
// Directed plus randomized bench for led_blinker_top against a step-count pattern model.
module tb_led_blinker_top;

   localparam int unsigned TD = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] inSwitch;
   logic       valid;
   logic       outBit1, outBit2, outBit3, outBit4;
   logic [3:0] w_led;

   int n_cmp  = 0;
   int n_fail = 0;
   int m_mode = 0;
   int m_el   = 0;

   always #50 clk = ~clk;

   assign w_led = {outBit4, outBit3, outBit2, outBit1};

   led_blinker_top #(
      .TICK_DIV (TD),
      .CNT_W    (2)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .inSwitch (inSwitch),
      .valid    (valid),
      .outBit1  (outBit1),
      .outBit2  (outBit2),
      .outBit3  (outBit3),
      .outBit4  (outBit4)
   );

   // Expected LEDs from mode and cycles elapsed since the load edge.
   function automatic logic [3:0] ref_led(input int mode, input int el);
      int s;
      s = el / int'(TD);
      case (mode)
         1:       return (s % 2 == 1) ? 4'b1111 : 4'b0000;
         2:       return 4'(1 << (s % 4));
         3:       return 4'(s % 16);
         default: return 4'b0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] exp);
      n_cmp++;
      assert (w_led === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b (mode %0d, elapsed %0d)", tag, w_led, exp, m_mode, m_el);
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic v, input logic [1:0] sw, input bit xsw);
      rstn  = r;
      valid = v;
      if (xsw) inSwitch = 2'bxx;
      else     inSwitch = sw;
      @(posedge clk);
      if (r) begin
         m_mode = 0;
         m_el   = 0;
      end else if (v && (int'(sw) != m_mode)) begin
         m_mode = int'(sw);
         m_el   = 0;
      end else begin
         m_el++;
      end
      #1;
      chk(tag, ref_led(m_mode, m_el));
   endtask

   initial begin
      rstn     = 1'b1;
      valid    = 1'b0;
      inSwitch = 2'b00;

      for (int i = 0; i < 10; i++) cyc("reset", 1'b1, 1'(i % 2), 2'($urandom), 1'b0);
      chk("reset_val", 4'b0000);
      for (int i = 0; i < 3; i++) cyc("post_reset", 1'b0, 1'b0, 2'($urandom), 1'b0);

      cyc("blink_load", 1'b0, 1'b1, 2'b01, 1'b0);
      chk("blink_init", 4'b0000);
      for (int i = 0; i < 9; i++)  cyc("blink_hold", 1'b0, 1'b1, 2'b01, 1'b0);
      for (int i = 0; i < 10; i++) cyc("blink_run", 1'b0, 1'b0, 2'($urandom), 1'b0);

      cyc("walk_load", 1'b0, 1'b1, 2'b10, 1'b0);
      chk("walk_init", 4'b0001);
      for (int i = 0; i < 20; i++) cyc("walk_run", 1'b0, 1'b0, 2'b00, 1'b0);

      cyc("count_load", 1'b0, 1'b1, 2'b11, 1'b0);
      chk("count_init", 4'b0000);
      for (int i = 0; i < 63; i++) cyc("count_run", 1'b0, 1'($urandom), 2'b11, 1'b0);
      chk("count_1111", 4'b1111);
      cyc("count_wrap", 1'b0, 1'b0, 2'b00, 1'b0);
      chk("count_wrap0", 4'b0000);
      for (int i = 0; i < 6; i++) cyc("count_more", 1'b0, 1'b0, 2'b00, 1'b0);

      cyc("off_load", 1'b0, 1'b1, 2'b00, 1'b0);
      chk("off_now", 4'b0000);
      for (int i = 0; i < 10; i++) cyc("x_ignored", 1'b0, 1'b0, 2'b00, 1'b1);

      cyc("count2_load", 1'b0, 1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 20; i++) cyc("count2_run", 1'b0, 1'b0, 2'b00, 1'b0);
      chk("count_0101", 4'b0101);
      cyc("mid_reset", 1'b1, 1'b0, 2'b00, 1'b0);
      chk("mid_reset_val", 4'b0000);
      for (int i = 0; i < 10; i++) cyc("stay_off", 1'b0, 1'b0, 2'($urandom), 1'b0);
      cyc("restart", 1'b0, 1'b1, 2'b10, 1'b0);
      chk("restart_walk", 4'b0001);

      for (int i = 0; i < 400; i++) begin
         cyc("random", 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) == 0),
             2'($urandom), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
